// File: rtl/l15_pkg.sv
// Shared definitions for the mem_l15 / l15_mem request interface.
// Imported by the L1.5-side responder and by the core's memory wrapper.
package l15_pkg;

  typedef enum logic [4:0] {
    LOAD_RQ  = 5'h00,
    STORE_RQ = 5'h01
  } rqtype_e;

  typedef enum logic [3:0] {
    LOAD_RET = 4'h0,
    ST_ACK   = 4'h4
  } rettype_e;

  typedef enum logic [2:0] {
    SIZE_1B = 3'd0,
    SIZE_2B = 3'd1,
    SIZE_4B = 3'd2,
    SIZE_8B = 3'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  // An access is aligned when its byte lane is a multiple of its size.
  function automatic logic is_aligned(input logic [2:0] size, input logic [2:0] lane);
    case (size)
      SIZE_1B: return 1'b1;
      SIZE_2B: return lane[0] == 1'b0;
      SIZE_4B: return lane[1:0] == 2'b00;
      SIZE_8B: return lane == 3'b000;
      default: return 1'b0;
    endcase
  endfunction

  // Lane mask for an aligned access; callers only use it when is_aligned holds.
  function automatic logic [7:0] byte_enable(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

endpackage

// File: rtl/l15_sp_ram.sv
// Single-port 64-bit byte-enabled synchronous RAM with registered read data.
// Behavioural model; an SRAM macro takes its place in hardening.
module l15_sp_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    be,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  // NOTE: the array and its read register have no reset; SRAM macros have none,
  // and clearing a large array would cost a cycle per word.
  logic [63:0] mem_q [DEPTH_WORDS];
  logic [63:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/l15_mem_responder.sv
// L1.5-side responder for the core's data-memory request interface: one load or
// store at a time on a local scratchpad, answered after a programmable latency.
module l15_mem_responder
  import l15_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [4:0]  mem_l15_rqtype,
  input  logic [2:0]  mem_l15_size,
  input  logic [31:0] mem_l15_address,
  input  logic [63:0] mem_l15_data,
  input  logic        mem_l15_val,
  output logic        l15_mem_header_ack,
  output logic        l15_mem_ack,
  output logic        l15_mem_val,
  output logic [3:0]  l15_mem_returntype,
  output logic [63:0] l15_mem_data_0,
  output logic [63:0] l15_mem_data_1,
  input  logic        mem_l15_req_ack,
  output logic        err,
  output logic        busy
);

  localparam int          AW     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 3;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        idle_hold_q, idle_hold_d;
  logic        store_ok_q, store_ok_d;
  logic        load_ok_q, load_ok_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  be_q, be_d;
  logic        header_ack_q, header_ack_d;
  logic        err_q, err_d;
  logic        val_q, val_d;
  rettype_e    rettype_q, rettype_d;
  logic        rd_valid_q, rd_valid_d;
  logic        busy_q, busy_d;

  logic        ram_we, ram_re;
  logic [63:0] ram_rdata;

  // Request decode straight from the held request fields.
  logic [31:0] offset;
  logic        in_range, aligned, size_ok, type_ok, is_store, req_ok;

  assign offset   = mem_l15_address - BASE_ADDR;
  assign in_range = {1'b0, offset} < SPAN;
  assign aligned  = is_aligned(mem_l15_size, mem_l15_address[2:0]);
  assign size_ok  = mem_l15_size <= SIZE_8B;
  assign is_store = mem_l15_rqtype == STORE_RQ;
  assign type_ok  = is_store || (mem_l15_rqtype == LOAD_RQ);
  assign req_ok   = in_range && aligned && size_ok && type_ok;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a variable unassigned and infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    idle_hold_d  = 1'b0;
    store_ok_d   = store_ok_q;
    load_ok_d    = load_ok_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    header_ack_d = 1'b0;
    err_d        = 1'b0;
    val_d        = val_q;
    rettype_d    = rettype_q;
    rd_valid_d   = rd_valid_q;
    ram_we       = 1'b0;
    ram_re       = 1'b0;

    case (state_q)
      IDLE: begin
        // The first IDLE cycle after a response never captures, so
        // back-to-back requests are spaced four cycles apart at zero latency.
        if (mem_l15_val && !idle_hold_q) begin
          state_d      = ACCEPT;
          header_ack_d = 1'b1;
          err_d        = !req_ok;
          store_ok_d   = req_ok && is_store;
          load_ok_d    = req_ok && !is_store;
          idx_d        = offset[AW+2:3];
          wdata_d      = mem_l15_data;
          be_d         = byte_enable(mem_l15_size[1:0], mem_l15_address[2:0]);
          rettype_d    = is_store ? ST_ACK : LOAD_RET;
        end
      end
      ACCEPT: begin
        ram_we = store_ok_q;
        if (LATENCY == 0) begin
          state_d    = RESP;
          ram_re     = load_ok_q;
          val_d      = 1'b1;
          rd_valid_d = load_ok_q;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_M1;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          ram_re     = load_ok_q;
          val_d      = 1'b1;
          rd_valid_d = load_ok_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (mem_l15_req_ack) begin
          state_d     = IDLE;
          val_d       = 1'b0;
          rd_valid_d  = 1'b0;
          idle_hold_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = state_d != IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      idle_hold_q  <= 1'b0;
      store_ok_q   <= 1'b0;
      load_ok_q    <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= 64'd0;
      be_q         <= 8'd0;
      header_ack_q <= 1'b0;
      err_q        <= 1'b0;
      val_q        <= 1'b0;
      rettype_q    <= LOAD_RET;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idle_hold_q  <= idle_hold_d;
      store_ok_q   <= store_ok_d;
      load_ok_q    <= load_ok_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      header_ack_q <= header_ack_d;
      err_q        <= err_d;
      val_q        <= val_d;
      rettype_q    <= rettype_d;
      rd_valid_q   <= rd_valid_d;
      busy_q       <= busy_d;
    end
  end

  // Write enable comes from state_q, so an asynchronous reset during ACCEPT
  // cancels the pending store before the commit edge.
  l15_sp_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (idx_q),
    .be    (be_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign l15_mem_header_ack = header_ack_q;
  assign l15_mem_ack        = header_ack_q;
  assign l15_mem_val        = val_q;
  assign l15_mem_returntype = rettype_q;
  // RAM read register qualified by a reset flop: zero after reset and for bad loads.
  assign l15_mem_data_0     = ram_rdata & {64{rd_valid_q}};
  assign l15_mem_data_1     = 64'd0;
  assign err                = err_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_l15_mem_responder.sv
// Directed bench for l15_mem_responder: a LATENCY=2 instance for function,
// stalls, errors and reset, plus a LATENCY=0 instance for back-to-back timing.
module tb_l15_mem_responder;
  import l15_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic [4:0]  rqtype;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic        val, req_ack;
  logic        hdr_ack, ack, rval, err, busy;
  logic [3:0]  rtype;
  logic [63:0] d0, d1;

  logic [4:0]  rq0;
  logic [2:0]  size0;
  logic [31:0] addr0;
  logic [63:0] wdata0;
  logic        val0, req_ack0;
  logic        hdr_ack0, ack0, rval0, err0, busy0;
  logic [3:0]  rtype0;
  logic [63:0] d0_0, d1_0;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  l15_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2)) dut (
    .clk(clk), .nrst(nrst),
    .mem_l15_rqtype(rqtype), .mem_l15_size(size), .mem_l15_address(addr),
    .mem_l15_data(wdata), .mem_l15_val(val),
    .l15_mem_header_ack(hdr_ack), .l15_mem_ack(ack), .l15_mem_val(rval),
    .l15_mem_returntype(rtype), .l15_mem_data_0(d0), .l15_mem_data_1(d1),
    .mem_l15_req_ack(req_ack), .err(err), .busy(busy)
  );

  l15_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(0)) dut_lat0 (
    .clk(clk), .nrst(nrst),
    .mem_l15_rqtype(rq0), .mem_l15_size(size0), .mem_l15_address(addr0),
    .mem_l15_data(wdata0), .mem_l15_val(val0),
    .l15_mem_header_ack(hdr_ack0), .l15_mem_ack(ack0), .l15_mem_val(rval0),
    .l15_mem_returntype(rtype0), .l15_mem_data_0(d0_0), .l15_mem_data_1(d1_0),
    .mem_l15_req_ack(req_ack0), .err(err0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request on the LATENCY=2 instance; req_ack is pulsed on the first RESP cycle.
  task automatic xact(input logic [4:0] rq, input logic [2:0] sz, input logic [31:0] a,
                      input logic [63:0] d, output logic e, output logic b, output int lat,
                      output logic [3:0] rt, output logic [63:0] rd);
    int n, hc;
    @(negedge clk);
    rqtype = rq; size = sz; addr = a; wdata = d; val = 1'b1;
    hc = -1; n = 0; e = 1'bx; b = 1'bx;
    while (hc < 0 && n < 20) begin
      @(negedge clk); n++;
      if (hdr_ack) begin hc = n; e = err; b = busy; end
    end
    val = 1'b0;
    lat = -1; rt = 'x; rd = 'x;
    while (hc >= 0 && lat < 0 && n < hc + 40) begin
      @(negedge clk); n++;
      if (rval) begin lat = n - hc - 1; rt = rtype; rd = d0; end
    end
    req_ack = 1'b1;
    @(negedge clk);
    req_ack = 1'b0;
  endtask

  task automatic run(input string tag, input logic [4:0] rq, input logic [2:0] sz,
                     input logic [31:0] a, input logic [63:0] d, input logic exp_err,
                     input logic [3:0] exp_rt, input logic chk_data, input logic [63:0] exp_data);
    logic e, b;
    int lat;
    logic [3:0] rt;
    logic [63:0] rd;
    xact(rq, sz, a, d, e, b, lat, rt, rd);
    check({tag, "_err"}, e, exp_err);
    check({tag, "_busy"}, b, 1'b1);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_rtype"}, rt, exp_rt);
    if (chk_data) check({tag, "_data"}, rd, exp_data);
  endtask

  initial begin
    int n, extra;
    logic stable;
    logic [63:0] held;
    int hcyc [4];
    int vcyc [4];
    int nh, nv;

    nrst = 1'b0;
    rqtype = '0; size = '0; addr = '0; wdata = '0; val = 1'b0; req_ack = 1'b0;
    rq0 = LOAD_RQ; size0 = 3'd3; addr0 = 32'h8; wdata0 = '0; val0 = 1'b0; req_ack0 = 1'b1;
    #22;
    check("reset_ctrl", {hdr_ack, ack, rval, err, busy, rtype}, '0);
    check("reset_d0", d0, 64'd0);
    check("reset_d1", d1, 64'd0);
    @(negedge clk);
    nrst = 1'b1;

    // Word store, partial store, full-word load.
    run("st_clr10", STORE_RQ, 3'd3, 32'h10, 64'h0, 1'b0, ST_ACK, 1'b0, '0);
    run("st_beef", STORE_RQ, 3'd2, 32'h10, 64'h0000_0000_DEAD_BEEF, 1'b0, ST_ACK, 1'b0, '0);
    run("ld_beef", LOAD_RQ, 3'd3, 32'h10, 64'h0, 1'b0, LOAD_RET, 1'b1, 64'h0000_0000_DEAD_BEEF);
    check("d1_zero", d1, 64'd0);

    // Byte stores with junk in disabled lanes.
    run("st_clr20", STORE_RQ, 3'd3, 32'h20, 64'h0, 1'b0, ST_ACK, 1'b0, '0);
    run("st_b21", STORE_RQ, 3'd0, 32'h21, 64'hFFFF_FFFF_FFFF_AAFF, 1'b0, ST_ACK, 1'b0, '0);
    run("st_b26", STORE_RQ, 3'd0, 32'h26, 64'hFFBB_FFFF_FFFF_FFFF, 1'b0, ST_ACK, 1'b0, '0);
    run("ld_bytes", LOAD_RQ, 3'd3, 32'h20, 64'h0, 1'b0, LOAD_RET, 1'b1, 64'h00BB_0000_0000_AA00);
    run("st_h24", STORE_RQ, 3'd1, 32'h24, 64'h0000_5678_0000_0000, 1'b0, ST_ACK, 1'b0, '0);
    run("ld_half", LOAD_RQ, 3'd1, 32'h24, 64'h0, 1'b0, LOAD_RET, 1'b1, 64'h00BB_5678_0000_AA00);

    // Stalled response with a new request held on val the whole time.
    run("st_30", STORE_RQ, 3'd3, 32'h30, 64'h0123_4567_89AB_CDEF, 1'b0, ST_ACK, 1'b0, '0);
    @(negedge clk);
    rqtype = LOAD_RQ; size = 3'd3; addr = 32'h30; wdata = '0; val = 1'b1;
    @(negedge clk);
    check("stall_hdr", hdr_ack, 1'b1);
    check("stall_ack_pair", ack, 1'b1);
    rqtype = STORE_RQ; wdata = 64'hCAFE_F00D_1234_5678;
    n = 0; extra = 0;
    while (!rval && n < 40) begin
      @(negedge clk); n++;
      if (hdr_ack) extra++;
    end
    check("stall_resp_cycles", n, 3);
    held = d0;
    check("stall_data", held, 64'h0123_4567_89AB_CDEF);
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!rval || d0 !== held || rtype !== LOAD_RET || hdr_ack) stable = 1'b0;
    end
    check("stall_stable5", stable, 1'b1);
    check("stall_no_capture", extra, 0);
    req_ack = 1'b1;
    @(negedge clk);
    req_ack = 1'b0;
    check("stall_val_drop", rval, 1'b0);
    check("stall_gap_hdr", hdr_ack, 1'b0);
    n = 0;
    while (!hdr_ack && n < 10) begin @(negedge clk); n++; end
    check("stall_capture_delay", n, 2);
    val = 1'b0;
    n = 0;
    while (!rval && n < 40) begin @(negedge clk); n++; end
    check("held_st_rtype", rtype, ST_ACK);
    req_ack = 1'b1;
    @(negedge clk);
    req_ack = 1'b0;
    run("ld_held_st", LOAD_RQ, 3'd3, 32'h30, 64'h0, 1'b0, LOAD_RET, 1'b1, 64'hCAFE_F00D_1234_5678);

    // Bad requests complete their handshake but change nothing.
    run("st_00", STORE_RQ, 3'd3, 32'h0, 64'h5A5A_5A5A_A5A5_A5A5, 1'b0, ST_ACK, 1'b0, '0);
    run("bad_range", LOAD_RQ, 3'd3, 32'h2000, 64'h0, 1'b1, LOAD_RET, 1'b1, 64'h0);
    run("bad_align", STORE_RQ, 3'd2, 32'h3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, ST_ACK, 1'b0, '0);
    run("ld_00", LOAD_RQ, 3'd3, 32'h0, 64'h0, 1'b0, LOAD_RET, 1'b1, 64'h5A5A_5A5A_A5A5_A5A5);
    run("bad_type", 5'h02, 3'd3, 32'h10, 64'h0, 1'b1, LOAD_RET, 1'b1, 64'h0);
    run("bad_size", LOAD_RQ, 3'd4, 32'h10, 64'h0, 1'b1, LOAD_RET, 1'b1, 64'h0);
    run("st_last", STORE_RQ, 3'd3, 32'h1FF8, 64'h1357_9BDF_2468_ACE0, 1'b0, ST_ACK, 1'b0, '0);
    run("ld_last", LOAD_RQ, 3'd3, 32'h1FF8, 64'h0, 1'b0, LOAD_RET, 1'b1, 64'h1357_9BDF_2468_ACE0);

    // Reset lands in the ACCEPT cycle, while the store commit is still pending.
    run("st_40", STORE_RQ, 3'd3, 32'h40, 64'h7777_7777_7777_7777, 1'b0, ST_ACK, 1'b0, '0);
    @(negedge clk);
    rqtype = STORE_RQ; size = 3'd3; addr = 32'h40; wdata = 64'h9999_9999_9999_9999; val = 1'b1;
    n = 0;
    while (!hdr_ack && n < 20) begin @(negedge clk); n++; end
    check("rst_hdr_seen", hdr_ack, 1'b1);
    nrst = 1'b0; val = 1'b0;
    #1;
    check("rst_outs_ctrl", {hdr_ack, ack, rval, err, busy, rtype}, '0);
    check("rst_outs_d0", d0, 64'd0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    run("ld_after_rst", LOAD_RQ, 3'd3, 32'h40, 64'h0, 1'b0, LOAD_RET, 1'b1, 64'h7777_7777_7777_7777);

    // LATENCY=0 instance: val held high and req_ack tied high.
    nh = 0; nv = 0;
    for (int i = 0; i < 4; i++) begin hcyc[i] = -1; vcyc[i] = -1; end
    @(negedge clk);
    val0 = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (hdr_ack0) begin if (nh < 4) hcyc[nh] = k; nh++; end
      if (rval0)    begin if (nv < 4) vcyc[nv] = k; nv++; end
    end
    val0 = 1'b0;
    check("lat0_hdr_count", nh, 4);
    check("lat0_val_count", nv, 4);
    check("lat0_first_hdr", hcyc[0], 1);
    check("lat0_hdr_gap1", hcyc[1] - hcyc[0], 4);
    check("lat0_hdr_gap3", hcyc[3] - hcyc[2], 4);
    check("lat0_val_after_hdr0", vcyc[0], hcyc[0] + 1);
    check("lat0_val_after_hdr2", vcyc[2], hcyc[2] + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
